// File: rtl/cache_pkg.sv
// Shared definitions for the cache line-refill controller:
// FSM encoding, AXI constants and line geometry helpers.
package cache_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } refill_state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   function automatic int line_beats(input int line_bits, input int data_width);
      return (1 << line_bits) / (data_width / 8);
   endfunction

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// AXI4 INCR read-burst master that refills one cache line per miss
// and streams the beats straight into the cache fill port.
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int C_ADDR_WIDTH     = 16,
   parameter int C_DATA_WIDTH     = 32,
   parameter int C_LINE_SIZE_BITS = 7
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      miss,
   input  logic [C_ADDR_WIDTH-1:0]   cpu_addr,
   input  logic                      err_clr,
   output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]                m_axi_arlen,
   output logic [2:0]                m_axi_arsize,
   output logic [1:0]                m_axi_arburst,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rlast,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   output logic [C_ADDR_WIDTH-1:0]   mem_addr,
   output logic [C_DATA_WIDTH-1:0]   mem_data_in,
   output logic [C_DATA_WIDTH/8-1:0] mem_wstb,
   output logic                      mem_data_valid,
   output logic                      mem_last,
   output logic                      refill_busy,
   output logic                      refill_err
);

   localparam int AW    = C_ADDR_WIDTH;
   localparam int LSB   = C_LINE_SIZE_BITS;
   localparam int BPW   = C_DATA_WIDTH / 8;
   localparam int BEATS = line_beats(C_LINE_SIZE_BITS, C_DATA_WIDTH);
   localparam int SZ    = clog2(BPW);
   localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);

   if (C_DATA_WIDTH != 32 && C_DATA_WIDTH != 64) begin : g_bad_dw
      $fatal(1, "cache_refill_ctrl: C_DATA_WIDTH must be 32 or 64");
   end
   if (BEATS < 1 || BEATS > 256) begin : g_bad_beats
      $fatal(1, "cache_refill_ctrl: line beats must be 1..256");
   end

   refill_state_e     state_q, state_d;
   logic [7:0]        beat_cnt_q, beat_cnt_d;
   logic [AW-1:0]     araddr_q, araddr_d;
   logic              err_q, err_d;
   logic              beat, is_last, err_det;
   logic [LSB+7:0]    off_full;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         beat_cnt_q <= '0;
         araddr_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         araddr_q   <= araddr_d;
         err_q      <= err_d;
      end
   end

   // Beat offset wraps inside the line; the tag/set bits come from araddr_q.
   assign off_full = {{LSB{1'b0}}, beat_cnt_q} << SZ;
   assign beat     = (state_q == S_DATA) && m_axi_rvalid;
   assign is_last  = (beat_cnt_q == LAST_BEAT);

   always_comb begin
      state_d        = state_q;
      beat_cnt_d     = beat_cnt_q;
      araddr_d       = araddr_q;
      err_det        = 1'b0;
      m_axi_araddr   = '0;
      m_axi_arlen    = '0;
      m_axi_arsize   = '0;
      m_axi_arburst  = '0;
      m_axi_arvalid  = 1'b0;
      m_axi_rready   = 1'b0;
      mem_addr       = '0;
      mem_data_in    = '0;
      mem_wstb       = '0;
      mem_data_valid = 1'b0;
      mem_last       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (miss) begin
               state_d    = S_ADDR;
               araddr_d   = {cpu_addr[AW-1:LSB], {LSB{1'b0}}};
               beat_cnt_d = '0;
            end
         end
         S_ADDR: begin
            m_axi_arvalid = 1'b1;
            m_axi_araddr  = araddr_q;
            m_axi_arlen   = LAST_BEAT;
            m_axi_arsize  = 3'(SZ);
            m_axi_arburst = AXI_BURST_INCR;
            if (m_axi_arready) state_d = S_DATA;
         end
         S_DATA: begin
            m_axi_rready = 1'b1;
            if (beat) begin
               mem_data_valid = 1'b1;
               mem_data_in    = m_axi_rdata;
               mem_wstb       = '1;
               mem_addr       = {araddr_q[AW-1:LSB], off_full[LSB-1:0]};
               mem_last       = is_last;
               beat_cnt_d     = beat_cnt_q + 8'd1;
               err_det        = (m_axi_rresp != AXI_RESP_OKAY) ||
                                (m_axi_rlast != is_last);
               if (is_last) state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!miss) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      err_d = err_det ? 1'b1 : (err_clr ? 1'b0 : err_q);
   end

   assign refill_busy = (state_q != S_IDLE);
   assign refill_err  = err_q;

   logic unused_ok;
   assign unused_ok = &{1'b0, cpu_addr[LSB-1:0], araddr_q[LSB-1:0],
                        off_full[LSB+7:LSB]};

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: reset, AR issue, gapped data,
// DONE hold, error detection/clear and mid-burst reset.
module tb_cache_refill_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        miss;
   logic [15:0] cpu_addr;
   logic        err_clr;
   logic [15:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rlast;
   logic        m_axi_rvalid;
   logic        m_axi_rready;
   logic [15:0] mem_addr;
   logic [31:0] mem_data_in;
   logic [3:0]  mem_wstb;
   logic        mem_data_valid;
   logic        mem_last;
   logic        refill_busy;
   logic        refill_err;

   int n_cmp = 0;
   int n_err = 0;
   int hs    = 0;
   logic err_m;

   cache_refill_ctrl #(
      .C_ADDR_WIDTH(16), .C_DATA_WIDTH(32), .C_LINE_SIZE_BITS(7)
   ) dut (
      .clk(clk), .reset_n(reset_n), .miss(miss), .cpu_addr(cpu_addr),
      .err_clr(err_clr),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wstb(mem_wstb),
      .mem_data_valid(mem_data_valid), .mem_last(mem_last),
      .refill_busy(refill_busy), .refill_err(refill_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (reset_n && m_axi_arvalid && m_axi_arready) hs++;

   task automatic chk(input string tag, input logic [63:0] o,
                      input logic [63:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one refill from IDLE; nb < 32 stops after nb beats.
   task automatic refill(input logic [15:0] a, input int ard,
                         input int bad, input int lastb, input int nb);
      logic [15:0] base;
      int hs0, k, c;
      logic rv, e;
      base = a & 16'hFF80;
      miss = 1'b1;
      cpu_addr = a;
      step();
      hs0 = hs;
      for (int i = 0; i <= ard; i++) begin
         if (i == ard) m_axi_arready = 1'b1;
         if (i == 1) cpu_addr = a ^ 16'h5A5A;
         #1;
         chk("arvalid", m_axi_arvalid, 1);
         chk("araddr", m_axi_araddr, base);
         chk("arlen", m_axi_arlen, 31);
         chk("arsize", m_axi_arsize, 2);
         chk("arburst", m_axi_arburst, 1);
         step();
      end
      m_axi_arready = 1'b0;
      chk("ar_hs", hs - hs0, 1);
      k = 0;
      c = 0;
      while (k < nb) begin
         rv = (c % 3) != 2;
         c++;
         m_axi_rvalid = rv;
         m_axi_rdata  = k;
         m_axi_rresp  = (k == bad) ? 2'b10 : 2'b00;
         m_axi_rlast  = (lastb >= 0) ? (k == lastb) : (k == 31);
         #1;
         chk("rready", m_axi_rready, 1);
         chk("err", refill_err, err_m);
         e = 1'b0;
         if (rv) begin
            chk("mdv", mem_data_valid, 1);
            chk("maddr", mem_addr, base + 16'(4 * k));
            chk("mdata", mem_data_in, k);
            chk("wstb", mem_wstb, 4'hF);
            chk("mlast", mem_last, k == 31);
            e = (k == bad) || (m_axi_rlast != (k == 31));
            k++;
         end else begin
            chk("mdv_gap", mem_data_valid, 0);
            chk("mlast_gap", mem_last, 0);
         end
         step();
         if (e) err_m = 1'b1;
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
   endtask

   initial begin
      reset_n = 1'b0;
      miss = 1'b1;
      cpu_addr = 16'h1234;
      err_clr = 1'b0;
      m_axi_arready = 1'b0;
      m_axi_rdata = '0;
      m_axi_rresp = 2'b00;
      m_axi_rlast = 1'b0;
      m_axi_rvalid = 1'b0;
      err_m = 1'b0;

      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_arvalid", m_axi_arvalid, 0);
         chk("rst_rready", m_axi_rready, 0);
         chk("rst_mdv", mem_data_valid, 0);
         chk("rst_busy", refill_busy, 0);
         chk("rst_err", refill_err, 0);
         chk("rst_araddr", m_axi_araddr, 0);
      end
      reset_n = 1'b1;
      #1;
      chk("rel_busy", refill_busy, 0);

      refill(16'h1234, 3, -1, -1, 32);
      chk("done_busy", refill_busy, 1);
      chk("done_rready", m_axi_rready, 0);
      chk("done_arvalid", m_axi_arvalid, 0);
      step();
      chk("hold_arvalid", m_axi_arvalid, 0);
      chk("hold_busy", refill_busy, 1);
      miss = 1'b0;
      step();
      chk("idle_busy", refill_busy, 0);
      chk("idle_arvalid", m_axi_arvalid, 0);
      chk("idle_err", refill_err, 0);

      refill(16'h2000, 0, 5, -1, 32);
      chk("resp_err", refill_err, 1);
      miss = 1'b0;
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("clr_err", refill_err, 0);
      err_m = 1'b0;

      refill(16'h4444, 1, -1, 30, 32);
      chk("rlast_err", refill_err, 1);
      miss = 1'b0;
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("clr_err2", refill_err, 0);
      err_m = 1'b0;

      refill(16'hABCD, 0, -1, -1, 10);
      m_axi_rvalid = 1'b1;
      m_axi_rdata = 32'd10;
      reset_n = 1'b0;
      #1;
      chk("b10_mdv", mem_data_valid, 1);
      chk("b10_addr", mem_addr, 16'hAB80 + 16'd40);
      step();
      chk("mrst_rready", m_axi_rready, 0);
      chk("mrst_mdv", mem_data_valid, 0);
      chk("mrst_busy", refill_busy, 0);
      reset_n = 1'b1;
      m_axi_rvalid = 1'b0;
      refill(16'h3456, 0, -1, -1, 32);
      miss = 1'b0;
      step();
      chk("end_busy", refill_busy, 0);
      chk("end_err", refill_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
